// File: rtl/tis_run_ctrl.sv
// Run controller for one TIS program execution: holds streams/core in reset while idle,
// checks every emitted output against the expected array and latches a pass/mismatch/timeout verdict.
module tis_run_ctrl #(
  parameter int WIDTH   = 11,
  parameter int DEPTH_W = 6,
  parameter int CYC_W   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CYC_W-1:0]   max_cycles,
  input  logic [DEPTH_W-1:0] exp_length,
  input  logic [WIDTH-1:0]   exp_data [2**DEPTH_W],
  input  logic               out_write,
  input  logic [WIDTH-1:0]   out_data,
  output logic               out_ready,
  output logic               stream_rst,
  output logic               core_en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic [DEPTH_W-1:0] fail_idx,
  output logic [CYC_W-1:0]   cycles
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_PASS = 2'd1;
  localparam logic [1:0] RES_MISM = 2'd2;
  localparam logic [1:0] RES_TOUT = 2'd3;

  state_t             state_q, state_d;
  logic               clr_q, clr_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic [DEPTH_W-1:0] idx_q, idx_d;
  logic [1:0]         result_q, result_d;
  logic [DEPTH_W-1:0] fail_idx_q, fail_idx_d;
  logic               stream_rst_q, stream_rst_d;
  logic               core_en_q, core_en_d;

  logic               xfer, mism, last_ok, tout;
  logic [CYC_W-1:0]   cyc_inc;
  logic [DEPTH_W-1:0] idx_nxt;

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    cycles_d   = cycles_q;
    idx_d      = idx_q;
    result_d   = result_q;
    fail_idx_d = fail_idx_q;

    xfer    = out_write && (state_q == S_RUN);
    cyc_inc = cycles_q + 1'b1;
    idx_nxt = idx_q + 1'b1;
    mism    = xfer && (out_data != exp_data[idx_q]);
    // an empty expected list passes immediately, ahead of any compare
    last_ok = (exp_length == '0) || (xfer && !mism && (idx_nxt == exp_length));
    tout    = (max_cycles != '0) && (cyc_inc == max_cycles);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_CLEAR;
          clr_d      = 1'b0;
          cycles_d   = '0;
          idx_d      = '0;
          result_d   = RES_NONE;
          fail_idx_d = '0;
        end
      end
      S_CLEAR: begin
        clr_d = 1'b1;
        if (clr_q) state_d = S_RUN;
      end
      S_RUN: begin
        cycles_d = (&cycles_q) ? cycles_q : cyc_inc;
        if (xfer && !mism) idx_d = idx_nxt;
        // verdict priority: mismatch, then final match, then timeout
        if (exp_length != '0 && mism) begin
          state_d    = S_DONE;
          result_d   = RES_MISM;
          fail_idx_d = idx_q;
        end else if (last_ok) begin
          state_d  = S_DONE;
          result_d = RES_PASS;
        end else if (tout) begin
          state_d  = S_DONE;
          result_d = RES_TOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // stream reset and core enable are registered so downstream resets are glitch-free
    stream_rst_d = (state_d != S_RUN);
    core_en_d    = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      clr_q        <= 1'b0;
      cycles_q     <= '0;
      idx_q        <= '0;
      result_q     <= RES_NONE;
      fail_idx_q   <= '0;
      stream_rst_q <= 1'b1;
      core_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      cycles_q     <= cycles_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      fail_idx_q   <= fail_idx_d;
      stream_rst_q <= stream_rst_d;
      core_en_q    <= core_en_d;
    end
  end

  assign out_ready  = (state_q == S_RUN);
  assign busy       = (state_q == S_CLEAR) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign stream_rst = stream_rst_q;
  assign core_en    = core_en_q;
  assign result     = result_q;
  assign fail_idx   = fail_idx_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_tis_run_ctrl.sv
// Bench for tis_run_ctrl: vector table of whole runs, verdicts checked through a scoreboard
// queue on each rise of done, plus hand sequences for reset, unlimited runs and held start.
module tb_tis_run_ctrl;
  localparam int WIDTH = 11, DEPTH_W = 6, CYC_W = 24;

  logic               clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_write = 1'b0;
  logic [CYC_W-1:0]   max_cycles = '0;
  logic [DEPTH_W-1:0] exp_length = '0;
  logic [WIDTH-1:0]   exp_data [2**DEPTH_W];
  logic [WIDTH-1:0]   out_data = '0;
  logic               out_ready, stream_rst, core_en, busy, done;
  logic [1:0]         result;
  logic [DEPTH_W-1:0] fail_idx;
  logic [CYC_W-1:0]   cycles;

  tis_run_ctrl #(.WIDTH(WIDTH), .DEPTH_W(DEPTH_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycles(max_cycles),
    .exp_length(exp_length), .exp_data(exp_data), .out_write(out_write),
    .out_data(out_data), .out_ready(out_ready), .stream_rst(stream_rst),
    .core_en(core_en), .busy(busy), .done(done), .result(result),
    .fail_idx(fail_idx), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  res;
    logic [5:0]  fi;
    logic [23:0] cyc;
  } sb_t;

  // xv: expected array, ev/ec: emitted values and the cycles they are offered on
  typedef struct packed {
    logic [5:0]        len;
    logic [3:0][10:0]  xv;
    logic [3:0][10:0]  ev;
    logic [3:0][15:0]  ec;
    logic [2:0]        ne;
    logic [23:0]       maxc;
    logic [1:0]        res;
    logic [5:0]        fi;
    logic [23:0]       cyc;
    logic [15:0]       dc;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[8];
  int   npass = 0, ntot = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    ntot++;
    if (act == expv) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // scoreboard: each new verdict is compared against the oldest pushed expectation
  always @(negedge clk) begin
    if (done && !done_prev) begin
      chk("sb_has_entry", longint'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_fail_idx", fail_idx, e.fi);
        chk("sb_cycles", cycles, e.cyc);
      end
    end
    done_prev <= done;
  end

  task automatic run_vec(input vec_t v, input int id);
    int c;
    bit fin;
    for (int j = 0; j < 64; j++) exp_data[j] = '0;
    for (int j = 0; j < 4; j++) exp_data[j] = v.xv[j];
    exp_length = v.len;
    max_cycles = v.maxc;
    sbq.push_back('{res: v.res, fi: v.fi, cyc: v.cyc});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1; fin = 1'b0;
    while (!fin && c < 300) begin
      if (c == 2) begin
        chk($sformatf("v%0d_c2_ready", id), out_ready, 0);
        chk($sformatf("v%0d_c2_srst", id), stream_rst, 1);
        chk($sformatf("v%0d_c2_busy", id), busy, 1);
      end
      if (c == 3) begin
        chk($sformatf("v%0d_c3_ready", id), out_ready, 1);
        chk($sformatf("v%0d_c3_srst", id), stream_rst, 0);
        chk($sformatf("v%0d_c3_core_en", id), core_en, 1);
      end
      if (done) begin
        out_write = 1'b0;
        chk($sformatf("v%0d_done_cycle", id), c, v.dc);
        chk($sformatf("v%0d_done_ready", id), out_ready, 0);
        chk($sformatf("v%0d_done_srst", id), stream_rst, 1);
        chk($sformatf("v%0d_done_core_en", id), core_en, 0);
        chk($sformatf("v%0d_done_busy", id), busy, 0);
        fin = 1'b1;
      end else begin
        out_write = 1'b0;
        for (int k = 0; k < int'(v.ne); k++)
          if (int'(v.ec[k]) == c) begin
            out_write = 1'b1;
            out_data  = v.ev[k];
          end
        @(negedge clk);
        c++;
      end
    end
    out_write = 1'b0;
    chk($sformatf("v%0d_finished", id), fin, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int j = 0; j < 64; j++) exp_data[j] = '0;

    //          len  xv (idx3..0)                        ev (idx3..0)                        ec (idx3..0)               ne  maxc   res fi cyc dc
    vt[0] = '{6'd3, {11'd0,11'd12,11'h7FF,11'd5},   {11'd0,11'd12,11'h7FF,11'd5},   {16'd0,16'd9,16'd6,16'd4}, 3'd3, 24'd0,  2'd1, 6'd0, 24'd7,  16'd10};
    vt[1] = '{6'd4, {11'd8,11'd6,11'd4,11'd1},      {11'd0,11'd0,11'd3,11'd1},      {16'd0,16'd0,16'd5,16'd3}, 3'd2, 24'd0,  2'd2, 6'd1, 24'd3,  16'd6};
    vt[2] = '{6'd2, {11'd0,11'd0,11'd10,11'd9},     {11'd0,11'd0,11'd0,11'd0},      {16'd0,16'd0,16'd0,16'd0}, 3'd0, 24'd10, 2'd3, 6'd0, 24'd10, 16'd13};
    vt[3] = '{6'd2, {11'd0,11'd0,11'd10,11'd9},     {11'd0,11'd0,11'd10,11'd9},     {16'd0,16'd0,16'd7,16'd4}, 3'd2, 24'd5,  2'd1, 6'd0, 24'd5,  16'd8};
    vt[4] = '{6'd0, {11'd0,11'd0,11'd0,11'd0},      {11'd0,11'd0,11'd0,11'd0},      {16'd0,16'd0,16'd0,16'd0}, 3'd0, 24'd0,  2'd1, 6'd0, 24'd1,  16'd4};
    vt[5] = '{6'd2, {11'd0,11'd0,11'd10,11'd9},     {11'd0,11'd0,11'd0,11'd100},    {16'd0,16'd0,16'd0,16'd5}, 3'd1, 24'd3,  2'd2, 6'd0, 24'd3,  16'd6};
    vt[6] = '{6'd1, {11'd0,11'd0,11'd0,11'd0},      {11'd0,11'd0,11'd0,11'd0},      {16'd0,16'd0,16'd0,16'd3}, 3'd1, 24'd0,  2'd1, 6'd0, 24'd1,  16'd4};
    vt[7] = '{6'd3, {11'd0,11'd2047,11'd0,11'd1},   {11'd0,11'd2046,11'd0,11'd1},   {16'd0,16'd8,16'd4,16'd3}, 3'd3, 24'd0,  2'd2, 6'd2, 24'd6,  16'd9};

    #12;
    chk("rst_stream_rst", stream_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_fail_idx", fail_idx, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_out_ready", out_ready, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vt[i], i);
      if (i == 1) begin
        // offers after a mismatch must be refused and the verdict must hold
        for (int k = 0; k < 3; k++) begin
          out_write = 1'b1; out_data = 11'd8;
          @(negedge clk);
          chk("hold_out_ready", out_ready, 0);
          chk("hold_result", result, 2);
          chk("hold_fail_idx", fail_idx, 1);
          chk("hold_cycles", cycles, 3);
        end
        out_write = 1'b0;
      end
    end

    // unlimited run with no output, then asynchronous reset mid-RUN
    for (int j = 0; j < 64; j++) exp_data[j] = '0;
    exp_length = 6'd1; max_cycles = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1;
    while (c < 1003) begin @(negedge clk); c++; end
    chk("unl_cycles", cycles, 1000);
    chk("unl_busy", busy, 1);
    chk("unl_out_ready", out_ready, 1);
    chk("unl_done", done, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stream_rst", stream_rst, 1);
    chk("arst_core_en", core_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_ready", out_ready, 0);
    chk("arst_cycles", cycles, 0);
    chk("arst_result", result, 0);
    @(negedge clk); rst_n = 1'b1;
    run_vec(vt[0], 8);

    // start held high in DONE restarts the run each time
    for (int j = 0; j < 64; j++) exp_data[j] = '0;
    exp_length = '0; max_cycles = '0;
    sbq.push_back('{res: 2'd1, fi: 6'd0, cyc: 24'd1});
    sbq.push_back('{res: 2'd1, fi: 6'd0, cyc: 24'd1});
    @(negedge clk); start = 1'b1;
    c = 0;
    while (c < 9) begin
      @(negedge clk); c++;
      if (c == 4) chk("held_done_first", done, 1);
      if (c == 5) begin
        chk("held_restart_busy", busy, 1);
        chk("held_restart_done", done, 0);
      end
      if (c == 8) begin
        chk("held_done_second", done, 1);
        start = 1'b0;
      end
      if (c == 9) begin
        chk("held_stays_done", done, 1);
        chk("held_result", result, 1);
      end
    end

    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
